// File: rtl/pipeline_pkg.sv
// Shared pipeline types: ALU operation codes, forwarding-source select and default widths.
package pipeline_pkg;

  localparam int DATA_WIDTH_DEF     = 32;
  localparam int REG_ADDR_WIDTH_DEF = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_t;

  typedef enum logic [1:0] {
    REG   = 2'd0,
    MEMWB = 2'd1,
    EXMEM = 2'd2
  } fwdsel_t;

endpackage

// File: rtl/forward_unit.sv
// Picks the forwarding source for one EX-stage source register; the younger EX/MEM result wins.
module forward_unit
  import pipeline_pkg::*;
#(
  parameter int AW = REG_ADDR_WIDTH_DEF
) (
  input  logic [AW-1:0] rs_i,
  input  logic [AW-1:0] exmem_rd_i,
  input  logic          exmem_regwrite_i,
  input  logic [AW-1:0] memwb_rd_i,
  input  logic          memwb_regwrite_i,
  output fwdsel_t       sel_o
);

  always_comb begin
    sel_o = REG;
    if (exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_i)) begin
      sel_o = EXMEM;
    end else if (memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_i)) begin
      sel_o = MEMWB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decode fields, detects RAW hazards and forwards ALU operands.
// Build option ID_EX_FWD_EN enables forwarding; without it, RAW hazards stall until writeback.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      idvalid,
  input  logic [REG_ADDR_WIDTH-1:0] idrs1,
  input  logic [REG_ADDR_WIDTH-1:0] idrs2,
  input  logic                      idusesrs1,
  input  logic                      idusesrs2,
  input  logic [REG_ADDR_WIDTH-1:0] idrd,
  input  logic [DATA_WIDTH-1:0]     idrd1,
  input  logic [DATA_WIDTH-1:0]     idrd2,
  input  logic [DATA_WIDTH-1:0]     idimm,
  input  logic                      idalusrc,
  input  logic [2:0]                idalucontrol,
  input  logic                      idregwrite,
  input  logic                      idmemread,
  input  logic                      idmemwrite,
  input  logic                      flush,
  input  logic [REG_ADDR_WIDTH-1:0] exmemrd,
  input  logic                      exmemregwrite,
  input  logic [DATA_WIDTH-1:0]     exmemresult,
  input  logic [REG_ADDR_WIDTH-1:0] memwbrd,
  input  logic                      memwbregwrite,
  input  logic [DATA_WIDTH-1:0]     memwbresult,
  output logic                      stall,
  output logic [DATA_WIDTH-1:0]     aluop1,
  output logic [DATA_WIDTH-1:0]     aluop2,
  output logic [2:0]                alucontrol,
  output logic [DATA_WIDTH-1:0]     storedata,
  output logic                      exvalid,
  output logic [REG_ADDR_WIDTH-1:0] exrd,
  output logic                      exregwrite,
  output logic                      exmemread,
  output logic                      exmemwrite
);

  logic                      valid_q, valid_d;
  logic [REG_ADDR_WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [DATA_WIDTH-1:0]     rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic                      alusrc_q, alusrc_d;
  logic [2:0]                aluctl_q, aluctl_d;
  logic                      regwrite_q, regwrite_d;
  logic                      memread_q, memread_d;
  logic                      memwrite_q, memwrite_d;

  logic                      ex_dep, hazard;
  fwdsel_t                   fwd1_sel, fwd2_sel;
  logic [DATA_WIDTH-1:0]     fwd_rs1, fwd_rs2;

  assign ex_dep = (rd_q != '0) &&
                  ((idusesrs1 && (idrs1 == rd_q)) || (idusesrs2 && (idrs2 == rd_q)));

`ifdef ID_EX_FWD_EN
  // Only a load in EX cannot be forwarded in time.
  assign hazard = valid_q && memread_q && ex_dep;
`else
  logic mem_dep;
  assign mem_dep = exmemregwrite && (exmemrd != '0) &&
                   ((idusesrs1 && (idrs1 == exmemrd)) || (idusesrs2 && (idrs2 == exmemrd)));
  assign hazard  = (valid_q && regwrite_q && ex_dep) || mem_dep;
`endif

  assign stall = idvalid && hazard && !flush;

  always_comb begin
    valid_d    = 1'b0;
    rs1_d      = '0;
    rs2_d      = '0;
    rd_d       = '0;
    rd1_d      = '0;
    rd2_d      = '0;
    imm_d      = '0;
    alusrc_d   = 1'b0;
    aluctl_d   = '0;
    regwrite_d = 1'b0;
    memread_d  = 1'b0;
    memwrite_d = 1'b0;
    if (!(flush || hazard)) begin
      valid_d    = idvalid;
      rs1_d      = idrs1;
      rs2_d      = idrs2;
      rd_d       = idrd;
      rd1_d      = idrd1;
      rd2_d      = idrd2;
      imm_d      = idimm;
      alusrc_d   = idalusrc;
      aluctl_d   = idalucontrol;
      regwrite_d = idregwrite && idvalid;
      memread_d  = idmemread && idvalid;
      memwrite_d = idmemwrite && idvalid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
      aluctl_q   <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      imm_q      <= imm_d;
      alusrc_q   <= alusrc_d;
      aluctl_q   <= aluctl_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
    end
  end

  forward_unit #(.AW(REG_ADDR_WIDTH)) u_fwd_rs1 (
    .rs_i             (rs1_q),
    .exmem_rd_i       (exmemrd),
    .exmem_regwrite_i (exmemregwrite),
    .memwb_rd_i       (memwbrd),
    .memwb_regwrite_i (memwbregwrite),
    .sel_o            (fwd1_sel)
  );

  forward_unit #(.AW(REG_ADDR_WIDTH)) u_fwd_rs2 (
    .rs_i             (rs2_q),
    .exmem_rd_i       (exmemrd),
    .exmem_regwrite_i (exmemregwrite),
    .memwb_rd_i       (memwbrd),
    .memwb_regwrite_i (memwbregwrite),
    .sel_o            (fwd2_sel)
  );

`ifdef ID_EX_FWD_EN
  function automatic logic [DATA_WIDTH-1:0] fwd_mux(input fwdsel_t sel,
                                                    input logic [DATA_WIDTH-1:0] reg_v,
                                                    input logic [DATA_WIDTH-1:0] exmem_v,
                                                    input logic [DATA_WIDTH-1:0] memwb_v);
    case (sel)
      EXMEM:   return exmem_v;
      MEMWB:   return memwb_v;
      default: return reg_v;
    endcase
  endfunction

  assign fwd_rs1 = fwd_mux(fwd1_sel, rd1_q, exmemresult, memwbresult);
  assign fwd_rs2 = fwd_mux(fwd2_sel, rd2_q, exmemresult, memwbresult);
`else
  // Stalls guarantee the register file already holds the value.
  logic unused_fwd;
  assign fwd_rs1    = rd1_q;
  assign fwd_rs2    = rd2_q;
  assign unused_fwd = ^{fwd1_sel, fwd2_sel, exmemresult, memwbresult};
`endif

  assign aluop1     = fwd_rs1;
  assign aluop2     = alusrc_q ? imm_q : fwd_rs2;
  assign storedata  = fwd_rs2;
  assign alucontrol = aluctl_q;
  assign exvalid    = valid_q;
  assign exrd       = rd_q;
  assign exregwrite = regwrite_q;
  assign exmemread  = memread_q;
  assign exmemwrite = memwrite_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage; expectations follow ID_EX_FWD_EN when it is defined.
module tb_id_ex_stage;
  import pipeline_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int W  = 12 + 3 * DW;

`ifdef ID_EX_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          idvalid, idusesrs1, idusesrs2, idalusrc, idregwrite, idmemread, idmemwrite, flush;
  logic [AW-1:0] idrs1, idrs2, idrd, exmemrd, memwbrd;
  logic [DW-1:0] idrd1, idrd2, idimm, exmemresult, memwbresult;
  logic [2:0]    idalucontrol;
  logic          exmemregwrite, memwbregwrite;
  logic          stall, exvalid, exregwrite, exmemread, exmemwrite;
  logic [DW-1:0] aluop1, aluop2, storedata;
  logic [2:0]    alucontrol;
  logic [AW-1:0] exrd;
  logic [W-1:0]  obs;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  last_exp;
  logic [AW-1:0] p_emrd, p_wbrd;
  logic          p_emrw, p_wbrw;
  logic [DW-1:0] p_emres, p_wbres;

  // em*/wb* describe the EX/MEM and MEM/WB stages while this instruction sits in EX.
  typedef struct {
    logic          v, u1, u2, alusrc, rw, mr, mw, fl;
    logic [AW-1:0] rs1, rs2, rd;
    logic [DW-1:0] d1, d2, imm;
    logic [2:0]    ctl;
    logic [AW-1:0] emrd, wbrd;
    logic          emrw, wbrw;
    logic [DW-1:0] emres, wbres;
  } txn_t;

  id_ex_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .idvalid(idvalid), .idrs1(idrs1), .idrs2(idrs2),
    .idusesrs1(idusesrs1), .idusesrs2(idusesrs2), .idrd(idrd), .idrd1(idrd1), .idrd2(idrd2),
    .idimm(idimm), .idalusrc(idalusrc), .idalucontrol(idalucontrol), .idregwrite(idregwrite),
    .idmemread(idmemread), .idmemwrite(idmemwrite), .flush(flush), .exmemrd(exmemrd),
    .exmemregwrite(exmemregwrite), .exmemresult(exmemresult), .memwbrd(memwbrd),
    .memwbregwrite(memwbregwrite), .memwbresult(memwbresult), .stall(stall), .aluop1(aluop1),
    .aluop2(aluop2), .alucontrol(alucontrol), .storedata(storedata), .exvalid(exvalid),
    .exrd(exrd), .exregwrite(exregwrite), .exmemread(exmemread), .exmemwrite(exmemwrite)
  );

  assign obs = {exvalid, exrd, alucontrol, exregwrite, exmemread, exmemwrite, aluop1, aluop2, storedata};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic txn_t nop();
    txn_t t;
    t = '{default: '0};
    return t;
  endfunction

  function automatic logic dep(input txn_t t, input logic [AW-1:0] rd);
    return (rd != '0) && ((t.u1 && t.rs1 == rd) || (t.u2 && t.rs2 == rd));
  endfunction

  function automatic logic [DW-1:0] fwd(input logic [AW-1:0] rs, input logic [DW-1:0] regv, input txn_t t);
    logic [DW-1:0] r;
    r = regv;
    if (FWD_ON && t.wbrw && t.wbrd != '0 && t.wbrd == rs) r = t.wbres;
    if (FWD_ON && t.emrw && t.emrd != '0 && t.emrd == rs) r = t.emres;
    return r;
  endfunction

  task automatic zero_inputs();
    idvalid = 0; idusesrs1 = 0; idusesrs2 = 0; idalusrc = 0; idregwrite = 0; idmemread = 0;
    idmemwrite = 0; flush = 0; idrs1 = '0; idrs2 = '0; idrd = '0; idrd1 = '0; idrd2 = '0;
    idimm = '0; idalucontrol = '0; exmemrd = '0; exmemregwrite = 0; exmemresult = '0;
    memwbrd = '0; memwbregwrite = 0; memwbresult = '0;
    p_emrd = '0; p_emrw = 0; p_emres = '0; p_wbrd = '0; p_wbrw = 0; p_wbres = '0;
  endtask

  // Called #1 after a rising edge; returns #1 after the next one.
  task automatic drive(input txn_t t);
    logic          hz, ex_v, ex_rw, ex_mr;
    logic [AW-1:0] ex_rd;
    logic [DW-1:0] op1, op2, sd;
    logic [W-1:0]  e;
    idvalid = t.v; idrs1 = t.rs1; idrs2 = t.rs2; idusesrs1 = t.u1; idusesrs2 = t.u2;
    idrd = t.rd; idrd1 = t.d1; idrd2 = t.d2; idimm = t.imm; idalusrc = t.alusrc;
    idalucontrol = t.ctl; idregwrite = t.rw; idmemread = t.mr; idmemwrite = t.mw; flush = t.fl;
    exmemrd = p_emrd; exmemregwrite = p_emrw; exmemresult = p_emres;
    memwbrd = p_wbrd; memwbregwrite = p_wbrw; memwbresult = p_wbres;
    #1;
    ex_v  = last_exp[W-1];
    ex_rd = last_exp[W-2 -: AW];
    ex_rw = last_exp[3*DW+2];
    ex_mr = last_exp[3*DW+1];
    if (FWD_ON) hz = ex_v && ex_mr && dep(t, ex_rd);
    else        hz = (ex_v && ex_rw && dep(t, ex_rd)) || (p_emrw && dep(t, p_emrd));
    check("stall", W'(stall), W'(t.v && hz && !t.fl));
    check("ex_out", obs, exp_q.pop_front());
    if (t.fl || hz) begin
      e = '0;
    end else begin
      op1 = fwd(t.rs1, t.d1, t);
      sd  = fwd(t.rs2, t.d2, t);
      op2 = t.alusrc ? t.imm : sd;
      e = {t.v, t.rd, t.ctl, t.v & t.rw, t.v & t.mr, t.v & t.mw, op1, op2, sd};
    end
    exp_q.push_back(e);
    last_exp = e;
    p_emrd = t.emrd; p_emrw = t.emrw; p_emres = t.emres;
    p_wbrd = t.wbrd; p_wbrw = t.wbrw; p_wbres = t.wbres;
    @(posedge clk);
    #1;
  endtask

  initial begin
    txn_t t, s;
    rst_n = 1'b0;
    zero_inputs();
    last_exp = '0;
    exp_q.push_back('0);
    @(posedge clk);
    #1;
    check("reset_out", obs, '0);
    check("reset_stall", W'(stall), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Pass-through: register operands, then immediate on operand 2.
    t = nop(); t.v = 1; t.rs1 = 1; t.rs2 = 2; t.u1 = 1; t.u2 = 1; t.rd = 10;
    t.d1 = 5; t.d2 = 7; t.ctl = ALU_ADD; t.rw = 1;
    drive(t);
    t = nop(); t.v = 1; t.rs1 = 1; t.u1 = 1; t.rd = 11; t.d1 = 5; t.d2 = 7;
    t.alusrc = 1; t.imm = 32'hFFFF_FFFC; t.ctl = ALU_SUB; t.rw = 1;
    drive(t);

    // Forwarding priority, MEM/WB fallback and x0.
    t = nop(); t.v = 1; t.rs1 = 3; t.u1 = 1; t.rd = 12; t.d1 = 32'h11; t.ctl = ALU_AND; t.rw = 1;
    t.emrd = 3; t.emrw = 1; t.emres = 32'h10; t.wbrd = 3; t.wbrw = 1; t.wbres = 32'h20;
    drive(t);
    t.rd = 13; t.emrw = 0;
    drive(t);
    t = nop(); t.v = 1; t.u1 = 1; t.u2 = 1; t.d1 = 32'h1234; t.d2 = 32'h5678; t.ctl = ALU_SLT;
    t.emrw = 1; t.emres = 32'h10; t.wbrw = 1; t.wbres = 32'h20;
    drive(t);

    // Load-use: lw x5 followed by a store of x5.
    t = nop(); t.v = 1; t.rs1 = 2; t.u1 = 1; t.rd = 5; t.d1 = 32'h40; t.alusrc = 1; t.imm = 4;
    t.ctl = ALU_ADD; t.rw = 1; t.mr = 1;
    drive(t);
    s = nop(); s.v = 1; s.rs1 = 6; s.u1 = 1; s.rs2 = 5; s.u2 = 1; s.d1 = 32'h100;
    s.d2 = 32'hDEAD; s.alusrc = 1; s.imm = 8; s.mw = 1; s.ctl = ALU_ADD;
    s.emrd = 5; s.emrw = 1; s.emres = 32'h44;
    drive(s);
    s.emrd = 0; s.emrw = 0; s.wbrd = 5; s.wbrw = 1; s.wbres = 32'h99;
    drive(s);
`ifndef ID_EX_FWD_EN
    s.wbrw = 0; s.d2 = 32'h99;
    drive(s);
`endif

    // Flush together with a load-use hazard, then a plain flush.
    t = nop(); t.v = 1; t.rd = 7; t.rw = 1; t.mr = 1; t.d1 = 32'h80; t.rs1 = 4; t.u1 = 1;
    drive(t);
    t = nop(); t.v = 1; t.rs1 = 7; t.u1 = 1; t.rd = 8; t.rw = 1; t.fl = 1; t.d1 = 32'hABC;
    drive(t);
    t.rs1 = 9;
    drive(t);

    // ALU producer followed by a dependent consumer.
    t = nop(); t.v = 1; t.rd = 1; t.rw = 1; t.ctl = ALU_ADD; t.d1 = 32'h50; t.d2 = 32'h5;
    drive(t);
    s = nop(); s.v = 1; s.rs1 = 1; s.u1 = 1; s.rd = 9; s.ctl = ALU_OR; s.d1 = 32'h77; s.rw = 1;
`ifdef ID_EX_FWD_EN
    s.emrd = 1; s.emrw = 1; s.emres = 32'h55;
    drive(s);
`else
    s.emrd = 1; s.emrw = 1; s.emres = 32'h55;
    drive(s);
    s.emrd = 0; s.emrw = 0; s.wbrd = 1; s.wbrw = 1; s.wbres = 32'h55;
    drive(s);
    s.wbrd = 0; s.wbrw = 0; s.d1 = 32'h55;
    drive(s);
`endif

    // Random traffic over a small register window to provoke matches.
    for (int i = 0; i < 60; i++) begin
      t = nop();
      t.v = ($urandom_range(0, 7) != 0);
      t.rs1 = AW'($urandom_range(0, 3)); t.rs2 = AW'($urandom_range(0, 3));
      t.rd = AW'($urandom_range(0, 3));
      t.u1 = 1'($urandom_range(0, 1)); t.u2 = 1'($urandom_range(0, 1));
      t.d1 = $urandom(); t.d2 = $urandom(); t.imm = $urandom();
      t.alusrc = 1'($urandom_range(0, 1)); t.ctl = 3'($urandom_range(0, 7));
      t.rw = 1'($urandom_range(0, 1)); t.mr = 1'($urandom_range(0, 1));
      t.mw = 1'($urandom_range(0, 1)); t.fl = ($urandom_range(0, 7) == 0);
      t.emrd = AW'($urandom_range(0, 3)); t.emrw = 1'($urandom_range(0, 1)); t.emres = $urandom();
      t.wbrd = AW'($urandom_range(0, 3)); t.wbrw = 1'($urandom_range(0, 1)); t.wbres = $urandom();
      drive(t);
    end

    // Asynchronous reset mid-stream with a live instruction in EX.
    t = nop(); t.v = 1; t.rd = 3; t.rw = 1; t.mw = 1; t.d1 = 32'hCAFE; t.d2 = 32'hBEEF; t.ctl = ALU_OR;
    drive(t);
    #2;
    rst_n = 1'b0;
    zero_inputs();
    #1;
    check("reset_mid_out", obs, '0);
    check("reset_mid_stall", W'(stall), '0);
    exp_q.delete();
    exp_q.push_back('0);
    last_exp = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    t = nop(); t.v = 1; t.rs1 = 2; t.u1 = 1; t.rd = 4; t.d1 = 32'h31; t.d2 = 32'h32;
    t.ctl = ALU_SUB; t.rw = 1;
    drive(t);
    drive(nop());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode and the execute-stage ALU.
- Latches decoded operands and controls.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards, stalls decode and inserts a bubble.
- Drives aluop1/aluop2/alucontrol directly into the ALU, plus forwarded store data and pass-through controls for the memory stage.

Parameters:
DATA_WIDTH, 32, operand/result width
REG_ADDR_WIDTH, 5, register index width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
idvalid  input  1  decode slot holds a real instruction
idrs1  input  REG_ADDR_WIDTH  source register 1 index
idrs2  input  REG_ADDR_WIDTH  source register 2 index
idusesrs1  input  1  instruction reads rs1
idusesrs2  input  1  instruction reads rs2
idrd  input  REG_ADDR_WIDTH  destination index
idrd1  input  DATA_WIDTH  register-file read data 1
idrd2  input  DATA_WIDTH  register-file read data 2
idimm  input  DATA_WIDTH  sign-extended immediate
idalusrc  input  1  1: aluop2 = immediate
idalucontrol  input  3  ALU operation code
idregwrite  input  1  writes rd
idmemread  input  1  load
idmemwrite  input  1  store
flush  input  1  kill decode-slot instruction (taken branch)
exmemrd  input  REG_ADDR_WIDTH  EX/MEM destination
exmemregwrite  input  1  EX/MEM writes rd
exmemresult  input  DATA_WIDTH  EX/MEM ALU result
memwbrd  input  REG_ADDR_WIDTH  MEM/WB destination
memwbregwrite  input  1  MEM/WB writes rd
memwbresult  input  DATA_WIDTH  MEM/WB writeback value
stall  output  1  hold PC and IF/ID this cycle
aluop1  output  DATA_WIDTH  ALU operand 1 (forwarded)
aluop2  output  DATA_WIDTH  ALU operand 2 (imm or forwarded rs2)
alucontrol  output  3  registered ALU op
storedata  output  DATA_WIDTH  forwarded rs2 for stores
exvalid  output  1  registered valid
exrd  output  REG_ADDR_WIDTH  registered destination
exregwrite  output  1  registered, gated by exvalid
exmemread  output  1  registered, gated by exvalid
exmemwrite  output  1  registered, gated by exvalid

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers clear to 0, so exvalid, controls, exrd and alucontrol are 0 and stall is 0.
  - aluop1/aluop2/storedata then read 0 (no forward matches rd 0).
  - Reset mid-operation discards the held instruction.
- Hazard: hazard = exvalid & exmemread & exrd!=0 & ((idusesrs1 & idrs1==exrd) | (idusesrs2 & idrs2==exrd)).
- Stall: stall = idvalid & hazard & ~flush. Purely combinational.
- Each rising edge, priority order:
  - flush or hazard: load a bubble (exvalid=0, all control bits 0, data regs don't-care but zeroed).
  - otherwise: load all id* fields, with exvalid=idvalid.
- Latency: one cycle from decode to ALU operands.
- Load-use: exactly one bubble, then the dependent instruction proceeds using the MEM/WB forward.
- Flush: wins over hazard; stall stays 0 on a flush cycle.
- Forwarding, combinational on registered rs1/rs2:
  - EX/MEM match (regwrite, rd!=0, rd==rs) has highest priority.
  - MEM/WB match next.
  - Otherwise the registered rd1/rd2.
  - Register x0 is never forwarded.
- Operand select: aluop2 = alusrc ? imm : fwd_rs2. storedata = fwd_rs2 always.
- Arithmetic: none; widths pass through unchanged.

Optional Feature:
- ID_EX_FWD_EN defined: forwarding as above.
- Undefined: forwarding muxes are removed and operands come from the registered read data.
  - hazard widens to any valid RAW against this register (exregwrite) or EX/MEM (exmemregwrite), rd!=0.
  - Stalls last until the producer reaches WB; the register file is write-before-read.

Decomposition:
- Package pipeline_pkg holds:
  - alucontrol encodings: ADD 000, SUB 001, AND 010, OR 011, SLT 101.
  - fwdsel_t enum: REG, MEMWB, EXMEM.
  - REG_ADDR_WIDTH default.
- Sub-module forward_unit: a pure combinational comparator producing fwdsel_t per source. It is instantiated twice, once for rs1 and once for rs2.

Test Plan:
- Reset: rst_n low mid-stream → all ex* outputs 0, stall 0, aluop1=aluop2=0 asynchronously.
- Pass-through: idrd1=5, idrd2=7, alucontrol=000, alusrc=0 → next cycle aluop1=5, aluop2=7, exvalid=1. With alusrc=1 and imm=0xFFFFFFFC → aluop2=0xFFFFFFFC.
- Forward priority: rs1=3, exmemrd=3 with 0x10, memwbrd=3 with 0x20 → aluop1=0x10. With exmemregwrite=0 → aluop1=0x20. With rs1=0 and both rd=0 → aluop1=idrd1 latched.
- Load-use: lw x5 in stage, decode rs2=5, usesrs2=1 → stall=1 one cycle, then bubble (exvalid=0). Next cycle the instruction is latched; memwbrd=5 with 0x99 gives storedata=0x99.
- Flush plus hazard same cycle → stall=0, bubble latched, exregwrite=0.
- Feature off (ID_EX_FWD_EN undefined): add x1 in stage, decode rs1=1 → stall held two cycles.
